mdio_slave_resp: RTL

// - Clause-22 MDIO management responder (PHY side); the far end of the MAC MDIO master (mdio_clk/mdio_out/mdio_out_en).
// - Oversamples MDC/MDIO on mclk, decodes frames addressed to cfg_phy_addr, issues register-bank read/write strobes and drives read data back.
// - Used as the PHY-emulation management port in the MAC subsystem and as the on-chip target for MDIO loopback.

---
 rtl/mdio_pkg.sv | 21 ++
 rtl/mdio_sync_edge.sv | 31 +++
 rtl/mdio_slave_resp.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/mdio_pkg.sv
// Shared types and constants for the Clause-22 MDIO responder.
package mdio_pkg;

  typedef enum logic [2:0] {
    PRE,
    ST,
    OP,
    PHYAD,
    REGAD,
    TA,
    DATA_RD,
    DATA_WR
  } mdio_state_e;

  localparam logic [1:0] MDIO_ST    = 2'b01;
  localparam logic [1:0] MDIO_OP_RD = 2'b10;
  localparam logic [1:0] MDIO_OP_WR = 2'b01;
  localparam int         MDIO_DW    = 16;
  localparam int         MDIO_AW    = 5;

endpackage

// File: rtl/mdio_sync_edge.sv
// Multi-flop synchronizer for one asynchronous bit, with rise/fall pulses
// derived from the last two synchronized samples.
module mdio_sync_edge #(
  parameter int SYNC_STG = 2
) (
  input  logic mclk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_STG-1:0] sr;
  logic                prev;

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      sr   <= '0;
      prev <= 1'b0;
    end else begin
      sr   <= {sr[SYNC_STG-2:0], d};
      prev <= sr[SYNC_STG-1];
    end
  end

  assign q    = sr[SYNC_STG-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/mdio_slave_resp.sv
// Clause-22 MDIO responder: decodes frames on oversampled MDC/MDIO, issues
// register-bank strobes and drives read data back on MDC falling edges.
module mdio_slave_resp
  import mdio_pkg::*;
#(
  parameter int PRE_LEN  = 32,
  parameter int SYNC_STG = 2
) (
  input  logic               mclk,
  input  logic               reset,
  input  logic [MDIO_AW-1:0] cfg_phy_addr,
  input  logic               mdio_clk,
  input  logic               mdio_in,
  output logic               mdio_out,
  output logic               mdio_out_en,
  output logic               reg_rd_req,
  output logic               reg_wr_en,
  output logic [MDIO_AW-1:0] reg_addr,
  output logic [MDIO_DW-1:0] reg_wdata,
  input  logic [MDIO_DW-1:0] reg_rd_data,
  output logic               frame_err,
  output logic               busy
);

  localparam logic [5:0] PRE_MAX = 6'(PRE_LEN);

  logic mdc_rise, mdc_fall, mdc_lvl_unused;
  logic din, din_rise_unused, din_fall_unused;

  mdio_sync_edge #(.SYNC_STG(SYNC_STG)) u_mdc_sync (
    .mclk(mclk), .reset(reset), .d(mdio_clk),
    .q(mdc_lvl_unused), .rise(mdc_rise), .fall(mdc_fall)
  );

  mdio_sync_edge #(.SYNC_STG(SYNC_STG)) u_mdio_sync (
    .mclk(mclk), .reset(reset), .d(mdio_in),
    .q(din), .rise(din_rise_unused), .fall(din_fall_unused)
  );

  mdio_state_e        state;
  logic [3:0]         bit_cnt;
  logic [5:0]         pre_cnt;
  logic               op_hi, is_read, ignore, last_bit, wr_pend;
  logic [MDIO_AW-2:0] phy_sr;
  logic [MDIO_DW-2:0] rx_sr;
  logic [MDIO_DW-1:0] tx_sr;
  logic [1:0]         rd_pipe;

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      state       <= PRE;
      bit_cnt     <= '0;
      pre_cnt     <= '0;
      op_hi       <= 1'b0;
      is_read     <= 1'b0;
      ignore      <= 1'b0;
      last_bit    <= 1'b0;
      wr_pend     <= 1'b0;
      phy_sr      <= '0;
      rx_sr       <= '0;
      tx_sr       <= '0;
      rd_pipe     <= '0;
      mdio_out    <= 1'b0;
      mdio_out_en <= 1'b0;
      reg_rd_req  <= 1'b0;
      reg_wr_en   <= 1'b0;
      reg_addr    <= '0;
      reg_wdata   <= '0;
      frame_err   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      reg_rd_req <= 1'b0;
      frame_err  <= 1'b0;
      wr_pend    <= 1'b0;
      reg_wr_en  <= wr_pend;
      // Read data is valid two mclk after the request pulse.
      rd_pipe    <= {rd_pipe[0], reg_rd_req};
      if (rd_pipe[1]) tx_sr <= reg_rd_data;

      if (mdc_rise) begin
        case (state)
          PRE: begin
            if (din) begin
              if (pre_cnt != PRE_MAX) pre_cnt <= pre_cnt + 6'd1;
            end else if (pre_cnt == PRE_MAX) begin
              state   <= ST;
              busy    <= 1'b1;
              ignore  <= 1'b0;
              pre_cnt <= '0;
            end else begin
              pre_cnt <= '0;
            end
          end
          ST: begin
            if ({1'b0, din} == MDIO_ST) begin
              state   <= OP;
              bit_cnt <= '0;
            end else begin
              frame_err <= 1'b1;
              state     <= PRE;
              busy      <= 1'b0;
            end
          end
          OP: begin
            if (bit_cnt == 4'd0) begin
              op_hi   <= din;
              bit_cnt <= 4'd1;
            end else if ({op_hi, din} == MDIO_OP_RD || {op_hi, din} == MDIO_OP_WR) begin
              is_read <= ({op_hi, din} == MDIO_OP_RD);
              state   <= PHYAD;
              bit_cnt <= '0;
            end else begin
              frame_err <= 1'b1;
              state     <= PRE;
              busy      <= 1'b0;
            end
          end
          PHYAD: begin
            phy_sr <= {phy_sr[MDIO_AW-3:0], din};
            if (bit_cnt == 4'd4) begin
              ignore  <= ({phy_sr, din} != cfg_phy_addr);
              state   <= REGAD;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          REGAD: begin
            reg_addr <= {reg_addr[MDIO_AW-2:0], din};
            if (bit_cnt == 4'd4) begin
              reg_rd_req <= is_read & ~ignore;
              state      <= TA;
              bit_cnt    <= '0;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          TA: begin
            if (is_read) begin
              if (bit_cnt == 4'd0) begin
                bit_cnt <= 4'd1;
              end else begin
                state    <= DATA_RD;
                bit_cnt  <= '0;
                last_bit <= 1'b0;
              end
            end else if (bit_cnt == 4'd0 && din) begin
              bit_cnt <= 4'd1;
            end else if (bit_cnt == 4'd1 && !din) begin
              state   <= DATA_WR;
              bit_cnt <= '0;
            end else begin
              frame_err <= ~ignore;
              state     <= PRE;
              busy      <= 1'b0;
            end
          end
          DATA_RD: begin
            if (bit_cnt == 4'd15) last_bit <= 1'b1;
            else bit_cnt <= bit_cnt + 4'd1;
          end
          DATA_WR: begin
            rx_sr <= {rx_sr[MDIO_DW-3:0], din};
            if (bit_cnt == 4'd15) begin
              reg_wdata <= {rx_sr, din};
              wr_pend   <= ~ignore;
              state     <= PRE;
              busy      <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          default: begin
            state <= PRE;
            busy  <= 1'b0;
          end
        endcase
      end else if (mdc_fall) begin
        // The bus is taken on the fall after TA1 and released on the fall after data bit 16.
        if (state == TA && is_read && bit_cnt == 4'd1 && !ignore) begin
          mdio_out_en <= 1'b1;
          mdio_out    <= 1'b0;
        end else if (state == DATA_RD) begin
          if (last_bit) begin
            mdio_out_en <= 1'b0;
            mdio_out    <= 1'b0;
            state       <= PRE;
            busy        <= 1'b0;
          end else begin
            mdio_out_en <= ~ignore;
            mdio_out    <= tx_sr[MDIO_DW-1] & ~ignore;
            tx_sr       <= {tx_sr[MDIO_DW-2:0], 1'b0};
          end
        end
      end
    end
  end

endmodule
